// File: rtl/opt_rand_gen_pkg.sv
// Shared types for the replica move generator: command/move bundle,
// FSM state encoding and default sizing for one annealer replica.
package opt_rand_gen_pkg;

    localparam int city_num = 30;
    localparam int base_log = 4;
    localparam int idx_w    = $clog2(city_num + 1);
    localparam int rand_w   = 32;

    typedef enum logic [1:0] {
        THR = 2'd0,
        TWO = 2'd1,
        OR  = 2'd2
    } com_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRAW_K  = 3'd1,
        S_DRAW_L  = 3'd2,
        S_DRAW_M  = 3'd3,
        S_DRAW_RM = 3'd4,
        S_DRAW_RX = 3'd5,
        S_HOLD    = 3'd6
    } state_t;

    typedef struct packed {
        com_t                com;
        logic [base_log-1:0] base_id;
        logic [idx_w-1:0]    k;
        logic [idx_w-1:0]    l;
        logic [idx_w-1:0]    m;
        logic [rand_w-1:0]   r_metropolis;
        logic [rand_w-1:0]   r_exchange;
    } opt_t;

endpackage

// File: rtl/opt_rand_gen_if.sv
// Request / move-command handshake bundle between a replica and its
// move generator. master = replica datapath, slave = generator.
interface opt_rand_gen_if;
    import opt_rand_gen_pkg::*;

    logic                req_valid;
    com_t                req_mode;
    logic                req_ready;
    logic [base_log-1:0] base_id;
    logic                opt_early;
    logic                opt_valid;
    logic                opt_ready;
    opt_t                opt;

    modport master (
        output req_valid, req_mode, base_id, opt_ready,
        input  req_ready, opt_early, opt_valid, opt
    );

    modport slave (
        input  req_valid, req_mode, base_id, opt_ready,
        output req_ready, opt_early, opt_valid, opt
    );

endinterface

// File: rtl/opt_rand_gen_xorshift_step.sv
// Combinational xorshift next-value function.
// x_i: current value, x_o: next value; SEED_W selects 32/64-bit shifts.
module opt_rand_gen_xorshift_step #(
    parameter int SEED_W = 64
) (
    input  logic [SEED_W-1:0] x_i,
    output logic [SEED_W-1:0] x_o
);

    logic [SEED_W-1:0] a;
    logic [SEED_W-1:0] b;

    generate
        if (SEED_W == 64) begin : g_w64
            assign a   = x_i ^ (x_i << 13);
            assign b   = a ^ (a >> 7);
            assign x_o = b ^ (b << 17);
        end else begin : g_w32
            assign a   = x_i ^ (x_i << 13);
            assign b   = a ^ (a >> 17);
            assign x_o = b ^ (b << 5);
        end
    endgenerate

endmodule

// File: rtl/opt_rand_gen.sv
// Random 2-opt / or-opt move generator, one per replica.
// Ports: clk, reset (sync high), seed_load/seed/n_seed, bus (slave), rej_cnt.
module opt_rand_gen
    import opt_rand_gen_pkg::*;
#(
    parameter int                CITY_NUM     = city_num,
    parameter int                IDX_W        = $clog2(CITY_NUM + 1),
    parameter int                SEED_W       = 64,
    parameter int                RAND_W       = rand_w,
    parameter logic [SEED_W-1:0] SEED_DEFAULT = SEED_W'(1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [SEED_W-1:0] seed,
    output logic [SEED_W-1:0] n_seed,
    opt_rand_gen_if.slave     bus,
    output logic [15:0]       rej_cnt
);

    localparam logic [IDX_W-1:0] CMAX = IDX_W'(CITY_NUM);

    state_t            state_q, state_d;
    logic [SEED_W-1:0] x_q, x_d, x_nxt;
    opt_t              opt_q, opt_d;
    logic [15:0]       rej_q, rej_d;
    logic              valid_q, valid_d;
    logic              early_q, early_d;
    logic              ready_q, ready_d;
    logic              rej_hit;

    logic [IDX_W-1:0]  c, lo, hi;
    logic              in_rng, m_ok, no_m;

    opt_rand_gen_xorshift_step #(.SEED_W(SEED_W)) u_step (
        .x_i (x_q),
        .x_o (x_nxt)
    );

    assign c      = x_nxt[IDX_W-1:0];
    assign in_rng = (c != '0) && (c <= CMAX);
    assign lo     = (c < opt_q.k) ? c : opt_q.k;
    assign hi     = (c < opt_q.k) ? opt_q.k : c;
    // With K<=2 nothing fits below K-1, and L at the top leaves nothing above.
    assign no_m   = (lo <= IDX_W'(2)) && (hi == CMAX);
    assign m_ok   = in_rng &&
                    ((({1'b0, c} + (IDX_W+1)'(1)) < {1'b0, opt_q.k}) ||
                     (c > opt_q.l));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        opt_d   = opt_q;
        valid_d = valid_q;
        ready_d = ready_q;
        early_d = 1'b0;
        rej_hit = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (seed_load) begin
                    x_d = (seed == '0) ? SEED_DEFAULT : seed;
                end
                if (bus.req_valid) begin
                    opt_d.base_id = bus.base_id;
                    ready_d       = 1'b0;
                    if (bus.req_mode == TWO || bus.req_mode == OR) begin
                        opt_d.com = bus.req_mode;
                        state_d   = S_DRAW_K;
                        if (bus.req_mode == TWO) begin
                            opt_d.m = '0;
                        end
                    end else begin
                        opt_d.com = THR;
                        state_d   = S_HOLD;
                        valid_d   = 1'b1;
                    end
                end
            end
            S_DRAW_K: begin
                x_d = x_nxt;
                if (in_rng) begin
                    opt_d.k = c;
                    state_d = S_DRAW_L;
                end else begin
                    rej_hit = 1'b1;
                end
            end
            S_DRAW_L: begin
                x_d = x_nxt;
                if (in_rng && c != opt_q.k) begin
                    opt_d.k = lo;
                    opt_d.l = hi;
                    if (opt_q.com == TWO) begin
                        state_d = S_DRAW_RM;
                        early_d = 1'b1;
                    end else if (no_m) begin
                        state_d = S_DRAW_K;
                    end else begin
                        state_d = S_DRAW_M;
                    end
                end else begin
                    rej_hit = 1'b1;
                end
            end
            S_DRAW_M: begin
                x_d = x_nxt;
                if (m_ok) begin
                    opt_d.m = c;
                    state_d = S_DRAW_RM;
                    early_d = 1'b1;
                end else begin
                    rej_hit = 1'b1;
                end
            end
            S_DRAW_RM: begin
                x_d                = x_nxt;
                opt_d.r_metropolis = x_nxt[RAND_W-1:0];
                state_d            = S_DRAW_RX;
            end
            S_DRAW_RX: begin
                x_d              = x_nxt;
                opt_d.r_exchange = x_nxt[RAND_W-1:0];
                state_d          = S_HOLD;
                valid_d          = 1'b1;
            end
            S_HOLD: begin
                if (bus.opt_ready) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
        rej_d = (rej_hit && rej_q != 16'hFFFF) ? rej_q + 16'd1 : rej_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            x_q           <= SEED_DEFAULT;
            opt_q         <= '0;
            opt_q.com     <= THR;
            opt_q.base_id <= bus.base_id;
            rej_q         <= '0;
            valid_q       <= 1'b0;
            early_q       <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            opt_q   <= opt_d;
            rej_q   <= rej_d;
            valid_q <= valid_d;
            early_q <= early_d;
            ready_q <= ready_d;
        end
    end

    assign n_seed        = x_q;
    assign rej_cnt       = rej_q;
    assign bus.req_ready = ready_q;
    assign bus.opt_valid = valid_q;
    assign bus.opt_early = early_q;
    assign bus.opt       = opt_q;

endmodule

// File: tb/tb_opt_rand_gen.sv
// Self-checking bench for opt_rand_gen (SEED_W=64, CITY_NUM=30)
// against a rejection-sampling reference model.
module tb_opt_rand_gen;
    import opt_rand_gen_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        seed_load;
    logic [63:0] seed;
    logic [63:0] n_seed;
    logic [15:0] rej_cnt;

    opt_rand_gen_if bus();

    opt_rand_gen #(
        .CITY_NUM     (30),
        .SEED_W       (64),
        .SEED_DEFAULT (64'd1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .seed_load (seed_load),
        .seed      (seed),
        .n_seed    (n_seed),
        .bus       (bus),
        .rej_cnt   (rej_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [63:0] m_x;
    int          m_k, m_l, m_m, m_rej, m_cyc, m_base, m_restarts;
    logic [31:0] m_rm, m_rx;
    com_t        m_com;

    function automatic logic [63:0] xs(input logic [63:0] v);
        logic [63:0] t;
        t = v;
        t = t ^ (t << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    task automatic model_reset();
        m_x = 64'd1; m_k = 0; m_l = 0; m_m = 0; m_rej = 0;
        m_rm = '0; m_rx = '0; m_com = THR;
    endtask

    task automatic draw(output int c);
        m_x = xs(m_x);
        m_cyc++;
        c = int'(m_x[4:0]);
    endtask

    task automatic rej_up();
        if (m_rej < 65535) m_rej++;
    endtask

    task automatic model_run(input com_t mode);
        int  c, a, b;
        bit  done;
        m_cyc = 0;
        if (mode != TWO && mode != OR) begin
            m_com = THR;
            return;
        end
        m_com = mode;
        if (mode == TWO) m_m = 0;
        done = 0;
        while (!done) begin
            draw(c);
            while (c < 1 || c > 30) begin rej_up(); draw(c); end
            a = c;
            draw(c);
            while (c < 1 || c > 30 || c == a) begin rej_up(); draw(c); end
            b = c;
            m_k = (a < b) ? a : b;
            m_l = (a < b) ? b : a;
            if (mode == TWO) begin
                done = 1;
            end else if (m_k <= 2 && m_l == 30) begin
                m_restarts++;
            end else begin
                draw(c);
                while (!((c >= 1 && c <= 30) && (c < m_k - 1 || c > m_l))) begin
                    rej_up();
                    draw(c);
                end
                m_m = c;
                done = 1;
            end
        end
        draw(c); m_rm = m_x[31:0];
        draw(c); m_rx = m_x[31:0];
    endtask

    task automatic run_txn(input com_t mode, input logic [3:0] base,
                           input bit load, input logic [63:0] sd,
                           input bit chk1, input logic [63:0] exp_step,
                           input int exp_k);
        int          n, early_n, early_cnt, stall;
        logic [63:0] x_start;
        opt_t        snap;
        chk("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_mode  = mode;
        bus.base_id   = base;
        seed_load     = load;
        seed          = sd;
        if (load) m_x = (sd == 0) ? 64'd1 : sd;
        x_start = m_x;
        m_base  = base;
        model_run(mode);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        seed_load     = 1'b0;
        bus.base_id   = 4'($urandom);
        chk("seed_at_accept", n_seed, x_start);
        n = 0; early_cnt = 0; early_n = -1;
        while (!bus.opt_valid && n < 2000) begin
            if (n == 0) chk("req_ready_busy", bus.req_ready, 0);
            if (bus.opt_early) begin early_cnt++; early_n = n; end
            seed_load     = 1'($urandom_range(0, 1));
            seed          = {$urandom, $urandom};
            bus.opt_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
            if (chk1 && n == 1) begin
                chk("first_step", n_seed, exp_step);
                chk("first_k", bus.opt.k, exp_k);
            end
        end
        seed_load = 1'b0;
        chk("latency", n, m_cyc);
        if (mode == TWO || mode == OR) begin
            chk("early_cnt", early_cnt, 1);
            chk("early_pos", early_n, m_cyc - 2);
            chk("k_lt_l", bus.opt.k < bus.opt.l, 1);
        end else begin
            chk("early_cnt", early_cnt, 0);
        end
        chk("com", bus.opt.com, m_com);
        chk("base_id", bus.opt.base_id, m_base);
        chk("k", bus.opt.k, m_k);
        chk("l", bus.opt.l, m_l);
        chk("m", bus.opt.m, m_m);
        chk("r_metropolis", bus.opt.r_metropolis, m_rm);
        chk("r_exchange", bus.opt.r_exchange, m_rx);
        chk("n_seed", n_seed, m_x);
        chk("rej_cnt", rej_cnt, m_rej);
        snap  = bus.opt;
        stall = $urandom_range(0, 3);
        for (int i = 0; i < stall; i++) begin
            bus.opt_ready = 1'b0;
            @(posedge clk); #1;
            chk("stall_valid", bus.opt_valid, 1);
            chk("stall_stable", bus.opt, snap);
        end
        bus.opt_ready = 1'b1;
        @(posedge clk); #1;
        bus.opt_ready = 1'($urandom_range(0, 1));
        chk("valid_drop", bus.opt_valid, 0);
        chk("req_ready_back", bus.req_ready, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 1);
        chk({tag, "_opt_valid"}, bus.opt_valid, 0);
        chk({tag, "_opt_early"}, bus.opt_early, 0);
        chk({tag, "_n_seed"}, n_seed, 64'd1);
        chk({tag, "_rej_cnt"}, rej_cnt, 0);
        chk({tag, "_com"}, bus.opt.com, THR);
        chk({tag, "_base_id"}, bus.opt.base_id, bus.base_id);
        chk({tag, "_klm"}, {bus.opt.k, bus.opt.l, bus.opt.m}, 0);
        chk({tag, "_rand"}, {bus.opt.r_metropolis, bus.opt.r_exchange}, 0);
    endtask

    task automatic watch_no_valid(input string tag);
        int seen;
        seen = 0;
        bus.opt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.opt_valid) seen++;
        end
        chk({tag, "_no_transfer"}, seen, 0);
    endtask

    typedef struct {
        logic [63:0] seed;
        logic [63:0] exp_load;
        logic [63:0] exp_step;
        int          exp_k;
        bit          same;
        com_t        mode;
    } vec_t;

    vec_t vt [5];

    initial begin
        int   r, gap;
        com_t md;
        logic [63:0] sd;

        vt[0] = '{64'd1, 64'd1, 64'h0000_0000_4082_2041, 1, 1'b0, TWO};
        vt[1] = '{64'd0, 64'd1, 64'h0000_0000_4082_2041, 1, 1'b0, OR};
        vt[2] = '{64'd2, 64'd2, 64'h0000_0000_8104_4082, 2, 1'b1, TWO};
        vt[3] = '{64'd4, 64'd4, 64'h0000_0001_0208_8104, 4, 1'b0, OR};
        vt[4] = '{64'd0, 64'd1, 64'h0000_0000_4082_2041, 1, 1'b1, TWO};

        m_restarts    = 0;
        reset         = 1'b1;
        seed_load     = 1'b0;
        seed          = '0;
        bus.req_valid = 1'b0;
        bus.req_mode  = THR;
        bus.base_id   = 4'h5;
        bus.opt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        reset = 1'b0;
        model_reset();

        // Seed table: explicit load or load together with the request
        foreach (vt[i]) begin
            if (!vt[i].same) begin
                seed_load = 1'b1;
                seed      = vt[i].seed;
                @(posedge clk); #1;
                seed_load = 1'b0;
                m_x       = vt[i].exp_load;
                chk("seed_load", n_seed, vt[i].exp_load);
            end
            run_txn(vt[i].mode, 4'(i), vt[i].same, vt[i].seed,
                    1'b1, vt[i].exp_step, vt[i].exp_k);
        end

        // THR keeps indices, words and generator
        run_txn(THR, 4'hA, 1'b0, 64'd0, 1'b0, 64'd0, 0);

        // Reset while in DRAW_L
        do_reset();
        bus.req_valid = 1'b1;
        bus.req_mode  = TWO;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("draw_l_k", bus.opt.k, 1);
        chk("draw_l_busy", bus.req_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_reset_state("rst_draw_l");
        watch_no_valid("rst_draw_l");

        // Reset while in HOLD
        bus.opt_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_mode  = TWO;
        for (int i = 0; i < 20 && !bus.opt_valid; i++) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
        end
        chk("hold_reached", bus.opt_valid, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        chk_reset_state("rst_hold");
        watch_no_valid("rst_hold");

        // Randomised traffic
        for (int t = 0; t < 1000; t++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                seed_load = 1'($urandom_range(0, 1));
                sd = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
                seed = sd;
                @(posedge clk); #1;
                if (seed_load) m_x = (sd == 0) ? 64'd1 : sd;
                seed_load = 1'b0;
            end
            r  = $urandom_range(0, 9);
            md = (r == 0) ? THR : (r < 5) ? TWO : OR;
            sd = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
            run_txn(md, 4'($urandom), ($urandom_range(0, 3) == 0), sd,
                    1'b0, 64'd0, 0);
        end

        $display("or-opt restarts exercised: %0d", m_restarts);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
